// File: rtl/cpu_ctrl.sv
// Instruction register, decoder and control FSM for the simple RISC machine.
// Drives every datapath control input from the latched 16-bit instruction; all outputs are Moore.
module cpu_ctrl #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s,
  input  logic          load,
  input  logic [15:0]   in,
  output logic          w,
  output logic          illegal,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic          write,
  output logic [1:0]    vsel,
  output logic          asel,
  output logic          bsel,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic [DW-1:0] sximm8,
  output logic [DW-1:0] sximm5
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] ir;

  function automatic logic signed [DW-1:0] sext8(input logic signed [7:0] v);
    return DW'(v);
  endfunction

  function automatic logic signed [DW-1:0] sext5(input logic signed [4:0] v);
    return DW'(v);
  endfunction

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_mov_imm, is_mov_reg, is_alu, is_cmp;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);

  assign sximm8 = sext8(ir[7:0]);
  assign sximm5 = sext5(ir[4:0]);

  // IR only accepts a new word while idle, so a running instruction cannot be corrupted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (load && (state == S_WAIT))
        ir <= in;
    end
  end

  always_comb begin
    state_nxt = state;
    w         = 1'b0;
    illegal   = 1'b0;
    readnum   = 3'd0;
    writenum  = 3'd0;
    write     = 1'b0;
    vsel      = 2'b00;
    asel      = 1'b0;
    bsel      = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    shift     = 2'b00;
    ALUop     = 2'b00;
    case (state)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        // MOV reg and MVN only need the B operand, so they skip GET_A
        if (is_mov_imm)                       state_nxt = S_WRITE_IMM;
        else if (is_mov_reg || (is_alu && op == 2'b11)) state_nxt = S_GET_B;
        else if (is_alu)                      state_nxt = S_GET_A;
        else begin
          illegal   = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WRITE_IMM: begin
        writenum  = rn;
        vsel      = 2'b10;
        write     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_GET_A: begin
        readnum   = rn;
        loada     = 1'b1;
        state_nxt = S_GET_B;
      end
      S_GET_B: begin
        readnum   = rm;
        loadb     = 1'b1;
        state_nxt = S_ALU;
      end
      S_ALU: begin
        shift = sh;
        if (is_mov_reg) begin
          asel      = 1'b1;
          ALUop     = 2'b00;
          loadc     = 1'b1;
          state_nxt = S_WRITE_REG;
        end else if (is_cmp) begin
          ALUop     = 2'b01;
          loads     = 1'b1;
          state_nxt = S_WAIT;
        end else begin
          ALUop     = op;
          loadc     = 1'b1;
          state_nxt = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        writenum  = rd;
        vsel      = 2'b00;
        write     = 1'b1;
        state_nxt = S_WAIT;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: one task per instruction class, hand-computed expectations.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] in;
  logic        w, illegal, write, asel, bsel, loada, loadb, loadc, loads;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5;
  logic [8:0]  ctl;

  int checks = 0;
  int errors = 0;

  cpu_ctrl #(.DW(16)) dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .w(w), .illegal(illegal), .readnum(readnum), .writenum(writenum),
    .write(write), .vsel(vsel), .asel(asel), .bsel(bsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .shift(shift), .ALUop(ALUop), .sximm8(sximm8), .sximm5(sximm5)
  );

  always #5 clk = ~clk;

  // {w, illegal, write, loada, loadb, loadc, loads, asel, bsel}
  assign ctl = {w, illegal, write, loada, loadb, loadc, loads, asel, bsel};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0000;
    #2;
    checks++;
    if (ctl !== 9'b1_0000_0000) begin
      errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 9'b1_0000_0000);
    end
    checks++;
    if ({readnum, writenum, vsel, ALUop, shift} !== 12'h000) begin
      errors++; $display("FAIL reset_fields: got %h expected 000", {readnum, writenum, vsel, ALUop, shift});
    end
    checks++;
    if ({sximm8, sximm5} !== 32'h0) begin
      errors++; $display("FAIL reset_imm: got %h expected 00000000", {sximm8, sximm5});
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mov_imm();
    load = 1'b1; s = 1'b1; in = 16'hD007;
    tick();  // edge 0 -> DECODE
    load = 1'b0; s = 1'b0;
    checks++;
    if (ctl !== 9'b0_0000_0000) begin
      errors++; $display("FAIL movimm_decode: got %b expected %b", ctl, 9'b0);
    end
    tick();  // edge 1 -> WRITE_IMM
    checks++;
    if ({ctl, writenum, vsel} !== {9'b0_0100_0000, 3'd0, 2'b10}) begin
      errors++; $display("FAIL movimm_write: got %b expected %b", {ctl, writenum, vsel}, {9'b0_0100_0000, 3'd0, 2'b10});
    end
    checks++;
    if (sximm8 !== 16'h0007) begin
      errors++; $display("FAIL movimm_sximm8: got %h expected 0007", sximm8);
    end
    tick();  // edge 2 -> WAIT
    checks++;
    if (ctl !== 9'b1_0000_0000) begin
      errors++; $display("FAIL movimm_done: got %b expected %b", ctl, 9'b1_0000_0000);
    end
  endtask

  task automatic test_mov_imm_neg();
    int pulses;
    pulses = 0;
    load = 1'b1; s = 1'b1; in = 16'hD1FE;
    tick();
    load = 1'b0; s = 1'b0;
    checks++;
    if ({sximm8, sximm5} !== {16'hFFFE, 16'hFFFE}) begin
      errors++; $display("FAIL movneg_imm: got %h expected FFFEFFFE", {sximm8, sximm5});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (write) begin
        pulses++;
        checks++;
        if (writenum !== 3'd1) begin
          errors++; $display("FAIL movneg_writenum: got %0d expected 1", writenum);
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL movneg_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_add();
    load = 1'b1; s = 1'b1; in = 16'hA148;
    tick();
    load = 1'b0; s = 1'b0;
    tick();  // GET_A
    checks++;
    if ({ctl, readnum} !== {9'b0_0010_0000, 3'd1}) begin
      errors++; $display("FAIL add_geta: got %b expected %b", {ctl, readnum}, {9'b0_0010_0000, 3'd1});
    end
    tick();  // GET_B
    checks++;
    if ({ctl, readnum} !== {9'b0_0001_0000, 3'd0}) begin
      errors++; $display("FAIL add_getb: got %b expected %b", {ctl, readnum}, {9'b0_0001_0000, 3'd0});
    end
    tick();  // ALU
    checks++;
    if ({ctl, shift, ALUop} !== {9'b0_0000_1000, 2'b01, 2'b00}) begin
      errors++; $display("FAIL add_alu: got %b expected %b", {ctl, shift, ALUop}, {9'b0_0000_1000, 2'b01, 2'b00});
    end
    tick();  // WRITE_REG
    checks++;
    if ({ctl, writenum, vsel} !== {9'b0_0100_0000, 3'd2, 2'b00}) begin
      errors++; $display("FAIL add_write: got %b expected %b", {ctl, writenum, vsel}, {9'b0_0100_0000, 3'd2, 2'b00});
    end
    tick();  // edge 5
    checks++;
    if (w !== 1'b1) begin
      errors++; $display("FAIL add_done: got %b expected 1", w);
    end
  endtask

  task automatic test_cmp();
    int wr;
    wr = 0;
    load = 1'b1; s = 1'b1; in = 16'hA900;
    tick();
    load = 1'b0; s = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (write) wr++;
    end
    tick();  // ALU
    checks++;
    if ({ctl, ALUop} !== {9'b0_0000_0100, 2'b01}) begin
      errors++; $display("FAIL cmp_alu: got %b expected %b", {ctl, ALUop}, {9'b0_0000_0100, 2'b01});
    end
    tick();  // edge 4
    if (write) wr++;
    checks++;
    if ({w, wr[0], wr[1]} !== 3'b100) begin
      errors++; $display("FAIL cmp_done: got w=%b writes=%0d expected w=1 writes=0", w, wr);
    end
  endtask

  task automatic test_mov_reg();
    load = 1'b1; s = 1'b1; in = 16'hC075;
    tick();
    load = 1'b0; s = 1'b0;
    tick();  // GET_B directly
    checks++;
    if ({ctl, readnum} !== {9'b0_0001_0000, 3'd5}) begin
      errors++; $display("FAIL movreg_getb: got %b expected %b", {ctl, readnum}, {9'b0_0001_0000, 3'd5});
    end
    tick();  // ALU
    checks++;
    if ({ctl, shift, ALUop} !== {9'b0_0000_1010, 2'b10, 2'b00}) begin
      errors++; $display("FAIL movreg_alu: got %b expected %b", {ctl, shift, ALUop}, {9'b0_0000_1010, 2'b10, 2'b00});
    end
    tick();
    checks++;
    if ({ctl, writenum} !== {9'b0_0100_0000, 3'd3}) begin
      errors++; $display("FAIL movreg_write: got %b expected %b", {ctl, writenum}, {9'b0_0100_0000, 3'd3});
    end
    tick();
    checks++;
    if (w !== 1'b1) begin
      errors++; $display("FAIL movreg_done: got %b expected 1", w);
    end
  endtask

  task automatic test_mvn();
    load = 1'b1; s = 1'b1; in = 16'hB882;
    tick();
    load = 1'b0; s = 1'b0;
    tick();
    checks++;
    if ({ctl, readnum} !== {9'b0_0001_0000, 3'd2}) begin
      errors++; $display("FAIL mvn_getb: got %b expected %b", {ctl, readnum}, {9'b0_0001_0000, 3'd2});
    end
    tick();
    checks++;
    if ({ctl, ALUop} !== {9'b0_0000_1000, 2'b11}) begin
      errors++; $display("FAIL mvn_alu: got %b expected %b", {ctl, ALUop}, {9'b0_0000_1000, 2'b11});
    end
    tick();
    checks++;
    if ({ctl, writenum} !== {9'b0_0100_0000, 3'd4}) begin
      errors++; $display("FAIL mvn_write: got %b expected %b", {ctl, writenum}, {9'b0_0100_0000, 3'd4});
    end
    tick();
  endtask

  task automatic test_illegal();
    load = 1'b1; s = 1'b0; in = 16'hE000;
    tick();
    load = 1'b0;
    checks++;
    if (ctl !== 9'b1_0000_0000) begin
      errors++; $display("FAIL illegal_load: got %b expected %b", ctl, 9'b1_0000_0000);
    end
    s = 1'b1;
    tick();  // DECODE
    s = 1'b0;
    checks++;
    if (ctl !== 9'b0_1000_0000) begin
      errors++; $display("FAIL illegal_pulse: got %b expected %b", ctl, 9'b0_1000_0000);
    end
    tick();
    checks++;
    if (ctl !== 9'b1_0000_0000) begin
      errors++; $display("FAIL illegal_back: got %b expected %b", ctl, 9'b1_0000_0000);
    end
    tick();
    checks++;
    if (ctl !== 9'b1_0000_0000) begin
      errors++; $display("FAIL illegal_idle: got %b expected %b", ctl, 9'b1_0000_0000);
    end
  endtask

  task automatic test_reset_mid();
    load = 1'b1; s = 1'b1; in = 16'hA148;
    tick();
    load = 1'b0; s = 1'b0;
    tick();
    tick();  // GET_B
    checks++;
    if (loadb !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: got loadb=%b expected 1", loadb);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({ctl, readnum, sximm8} !== {9'b1_0000_0000, 3'd0, 16'h0000}) begin
      errors++; $display("FAIL rstmid_abort: got %b expected %b", {ctl, readnum, sximm8}, {9'b1_0000_0000, 3'd0, 16'h0000});
    end
    tick();
    reset = 1'b0;
    // restart, then try to overwrite IR while busy
    load = 1'b1; s = 1'b1; in = 16'hA148;
    tick();  // DECODE
    s = 1'b0; in = 16'h0000;
    tick();  // GET_A
    checks++;
    if ({ctl, readnum} !== {9'b0_0010_0000, 3'd1}) begin
      errors++; $display("FAIL busyload_geta: got %b expected %b", {ctl, readnum}, {9'b0_0010_0000, 3'd1});
    end
    load = 1'b0;
    tick();
    tick();  // ALU
    checks++;
    if ({shift, sximm8} !== {2'b01, 16'h0048}) begin
      errors++; $display("FAIL busyload_ir: got %h expected %h", {shift, sximm8}, {2'b01, 16'h0048});
    end
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    load = 1'b1; s = 1'b1; in = 16'hD203;
    tick();  // DECODE
    load = 1'b0;
    tick();  // WRITE_IMM, s still high but ignored
    checks++;
    if ({ctl, writenum} !== {9'b0_0100_0000, 3'd2}) begin
      errors++; $display("FAIL b2b_write: got %b expected %b", {ctl, writenum}, {9'b0_0100_0000, 3'd2});
    end
    tick();  // WAIT
    tick();  // s held -> DECODE again
    s = 1'b0;
    checks++;
    if (w !== 1'b0) begin
      errors++; $display("FAIL b2b_restart: got w=%b expected 0", w);
    end
    tick();
    checks++;
    if ({ctl, writenum} !== {9'b0_0100_0000, 3'd2}) begin
      errors++; $display("FAIL b2b_write2: got %b expected %b", {ctl, writenum}, {9'b0_0100_0000, 3'd2});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_mov_imm_neg();
    test_add();
    test_cmp();
    test_mov_reg();
    test_mvn();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
